axi_master_src: RTL and testbench

- Upstream source stage for the valid/ready slave channel.
- A local producer pushes 32-bit words into a small FIFO. The block drains the FIFO onto the channel `data`/`valid`, obeying the handshake rules, and marks burst boundaries with `last`.
- The channel-side outputs connect directly to the slave's `data`/`valid`/`ready` ports.

---
 rtl/axi_master_src.sv | 103 ++++++++++
 tb/tb_axi_master_src.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_src.sv
// Valid/ready source stage: producer FIFO drained into a registered data/valid/last channel.
// Optional `STALL_CNT_EN adds a saturating 16-bit stall counter output.
module axi_master_src #(
  parameter int DEPTH     = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [31:0]              wr_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic [31:0]              data,
  output logic                     valid,
  input  logic                     ready,
  output logic                     last
`ifdef STALL_CNT_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam logic [AW:0]   PTR_ONE  = 1;
  localparam logic [CW-1:0] BEAT_ONE = 1;
  localparam logic [CW-1:0] BEAT_MAX = CW'(BURST_LEN - 1);

  logic [31:0]   mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]   data_q, data_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] beat_q, beat_d;
  logic          empty, push, pop, beat_done, beat_wrap;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign level     = wr_ptr_q - rd_ptr_q;
  assign beat_done = valid_q && ready;
  assign beat_wrap = (beat_q == BEAT_MAX);
  assign push      = wr_en && !full;
  assign pop       = (!valid_q || beat_done) && !empty;

  assign data  = data_q;
  assign valid = valid_q;
  assign last  = valid_q && beat_wrap;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    data_d   = data_q;
    valid_d  = valid_q;
    beat_d   = beat_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      data_d   = mem_q[rd_ptr_q[AW-1:0]];
      valid_d  = 1'b1;
    end else if (beat_done) begin
      valid_d  = 1'b0;
    end
    if (beat_done) beat_d = beat_wrap ? '0 : beat_q + BEAT_ONE;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      beat_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      beat_q   <= beat_d;
    end
  end

  // NOTE: the storage array has no reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

`ifdef STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (valid_q && !ready && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_axi_master_src.sv
// Directed self-checking bench for axi_master_src: DEPTH=4 with BURST_LEN=4 and BURST_LEN=1 instances
// sharing one stimulus stream.
module tb_axi_master_src;

  logic        clk = 1'b0;
  logic        rst, wr_en, ready;
  logic [31:0] wr_data;
  logic        full, valid, last, full1, valid1, last1;
  logic [2:0]  level, level1;
  logic [31:0] data, data1;
`ifdef STALL_CNT_EN
  logic [15:0] stall_cnt, stall_cnt1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_master_src #(.DEPTH(4), .BURST_LEN(4)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full), .level(level),
    .data(data), .valid(valid), .ready(ready), .last(last)
`ifdef STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  axi_master_src #(.DEPTH(4), .BURST_LEN(1)) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full1), .level(level1),
    .data(data1), .valid(valid1), .ready(ready), .last(last1)
`ifdef STALL_CNT_EN
    , .stall_cnt(stall_cnt1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    wr_en = 1'b0;
    ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Streams n words with ready high from a freshly reset state; word i is presented after edge i+2.
  task automatic stream(input int n, input logic [31:0] base);
    ready   = 1'b1;
    wr_en   = 1'b1;
    wr_data = base;
    tick();
    for (int i = 0; i < n; i++) begin
      if (i + 1 < n) wr_data = base + 32'(i + 1);
      else           wr_en   = 1'b0;
      tick();
      check($sformatf("stream_valid[%0d]", i), {31'b0, valid}, 32'd1);
      check($sformatf("stream_data[%0d]", i), data, base + 32'(i));
      check($sformatf("stream_last[%0d]", i), {31'b0, last}, {31'b0, (i % 4) == 3});
      check($sformatf("stream_last_bl1[%0d]", i), {31'b0, last1}, {31'b0, valid1});
      check($sformatf("stream_valid_bl1[%0d]", i), {31'b0, valid1}, 32'd1);
    end
    tick();
    check("stream_idle_valid", {31'b0, valid}, 32'd0);
    check("stream_idle_last", {31'b0, last}, 32'd0);
  endtask

  initial begin
    logic [31:0] fw [6];

    rst = 1'b1; wr_en = 1'b0; ready = 1'b0; wr_data = '0;
    #2;
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_level", {29'b0, level}, 32'd0);
    check("rst_full", {31'b0, full}, 32'd0);
    check("rst_last", {31'b0, last}, 32'd0);
    check("rst_data", data, 32'd0);
    do_reset();

    // Basic transfer: visible one edge after the write, gone after the handshake edge.
    ready = 1'b1; wr_en = 1'b1; wr_data = 32'hA5A5_0001;
    tick();
    wr_en = 1'b0;
    check("basic_level_after_write", {29'b0, level}, 32'd1);
    check("basic_valid_after_write", {31'b0, valid}, 32'd0);
    tick();
    check("basic_valid", {31'b0, valid}, 32'd1);
    check("basic_data", data, 32'hA5A5_0001);
    check("basic_level_after_load", {29'b0, level}, 32'd0);
    tick();
    check("basic_valid_after_hs", {31'b0, valid}, 32'd0);
    check("basic_data_kept", data, 32'hA5A5_0001);

    // Backpressure: three words, five held cycles, then release.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 32'hB000_0000 + 32'(i);
      tick();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_hold_valid[%0d]", i), {31'b0, valid}, 32'd1);
      check($sformatf("bp_hold_data[%0d]", i), data, 32'hB000_0000);
    end
`ifdef STALL_CNT_EN
    // valid rises after edge 2, so edge 3 (third write) stalls as well as the five hold edges.
    check("bp_stall_cnt", {16'b0, stall_cnt}, 32'd6);
`endif
    ready = 1'b1;
    tick();
    check("bp_data_w1", data, 32'hB000_0001);
    check("bp_valid_w1", {31'b0, valid}, 32'd1);
    tick();
    check("bp_data_w2", data, 32'hB000_0002);
    check("bp_valid_w2", {31'b0, valid}, 32'd1);
    tick();
    check("bp_valid_end", {31'b0, valid}, 32'd0);
`ifdef STALL_CNT_EN
    check("bp_stall_cnt_final", {16'b0, stall_cnt}, 32'd6);
`endif

    // Full FIFO: word 0 in the output register, words 1-4 queued, word 5 dropped.
    do_reset();
    for (int i = 0; i < 6; i++) fw[i] = 32'hF000_0010 + 32'(i);
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = fw[i];
      tick();
      if (i == 4) begin
        check("full_flag_at_4", {31'b0, full}, 32'd1);
        check("full_level_at_4", {29'b0, level}, 32'd4);
      end
    end
    wr_en = 1'b0;
    check("full_flag_after_drop", {31'b0, full}, 32'd1);
    check("full_level_after_drop", {29'b0, level}, 32'd4);
    check("full_head", data, fw[0]);
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("full_drain_valid[%0d]", i), {31'b0, valid}, 32'd1);
      check($sformatf("full_drain_data[%0d]", i), data, fw[i]);
      tick();
    end
    check("full_drain_end_valid", {31'b0, valid}, 32'd0);
    check("full_drain_end_level", {29'b0, level}, 32'd0);

    // Burst framing: 8 beats, last on beats 3 and 7 (BURST_LEN=1 instance: every beat).
    do_reset();
    stream(8, 32'hC0DE_0000);

    // Concurrent read/write at level 2 for 10 cycles.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 32'hD000_0000 + 32'(i);
      tick();
    end
    check("rw_level_start", {29'b0, level}, 32'd2);
    check("rw_head_start", data, 32'hD000_0000);
    ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wr_data = 32'hD000_0000 + 32'(k + 3);
      tick();
      check($sformatf("rw_level[%0d]", k), {29'b0, level}, 32'd2);
      check($sformatf("rw_full[%0d]", k), {31'b0, full}, 32'd0);
      check($sformatf("rw_data[%0d]", k), data, 32'hD000_0000 + 32'(k + 1));
    end
    wr_en = 1'b0;

    // Reset mid-burst: beat 0 done, beat 1 presented, two words queued.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 32'hE000_0000 + 32'(i);
      tick();
    end
    wr_en = 1'b0; ready = 1'b1;
    tick();
    ready = 1'b0;
    check("mid_data_beat1", data, 32'hE000_0001);
    check("mid_level_before", {29'b0, level}, 32'd2);
    #2 rst = 1'b1;
    #1;
    check("mid_valid_async", {31'b0, valid}, 32'd0);
    check("mid_level_async", {29'b0, level}, 32'd0);
    check("mid_last_async", {31'b0, last}, 32'd0);
    tick();
    rst = 1'b0;
    stream(4, 32'h5EED_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
